// File: rtl/coef_load_ctrl.sv
// coef_load_ctrl: sequences a FIR coefficient reload. It stalls the filter
// (o_filt_hold), waits DRAIN_CYCLES, then streams 17 host bytes into the
// coefficient shift register: tap_num first, then h_15 down to h_0.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   i_start            request a reload (IDLE only)
//   i_abort            cancel a reload in DRAIN/LOAD
//   i_s_valid/i_s_data host byte stream
//   o_s_ready          combinational ready, high in LOAD without abort
//   o_cfg_enable       coefficient register config enable
//   o_cfg_data_enable  one-cycle shift pulse
//   o_cfg_data         byte to shift
//   o_filt_hold        FIR datapath stall
//   o_busy             not IDLE
//   o_done / o_err     completion / abort-or-timeout pulses
//   o_word_cnt         bytes accepted in the current load
module coef_load_ctrl #(
    parameter int DRAIN_CYCLES = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_s_valid,
    input  logic [7:0] i_s_data,
    output logic       o_s_ready,
    output logic       o_cfg_enable,
    output logic       o_cfg_data_enable,
    output logic [7:0] o_cfg_data,
    output logic       o_filt_hold,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [4:0] o_word_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_LOAD,
        S_FINISH
    } state_t;

    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES);
    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);
    localparam logic [4:0] LAST_WORD  = 5'd16;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_drain_cnt;
    logic [7:0] r_idle_cnt;
    logic       r_cfg_enable;
    logic       r_cfg_data_enable;
    logic [7:0] r_cfg_data;
    logic       r_filt_hold;
    logic       r_done;
    logic       r_err;
    logic [4:0] r_word_cnt;

    logic       w_start;
    logic       w_abort;
    logic       w_xfer;
    logic       w_last;
    logic       w_timeout;
    logic       w_cfg_enable_n;
    logic       w_filt_hold_n;
    logic       w_done_n;
    logic       w_err_n;

    assign w_start   = (r_state == S_IDLE) && i_start;
    assign w_abort   = i_abort &&
                       ((r_state == S_DRAIN) || (r_state == S_LOAD));
    assign w_xfer    = i_s_valid && o_s_ready;
    assign w_last    = w_xfer && (r_word_cnt == LAST_WORD);
    // The idle counter reaches TIMEOUT on this edge; abort wins over it.
    assign w_timeout = (r_state == S_LOAD) && !i_abort && !w_xfer &&
                       (r_idle_cnt == IDLE_LIMIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A count of 0 or 1 both leave after this cycle.
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (r_drain_cnt <= 8'd1) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_FINISH;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Output logic: combinational outputs and next values of registered ones
    always_comb begin
        o_s_ready      = (r_state == S_LOAD) && !i_abort;
        o_busy         = (r_state != S_IDLE);
        w_cfg_enable_n = (w_next == S_LOAD) || (w_next == S_FINISH);
        w_filt_hold_n  = (w_next != S_IDLE);
        w_done_n       = (r_state == S_FINISH);
        w_err_n        = w_abort || w_timeout;
    end

    // Registered outputs and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_enable      <= 1'b0;
            r_cfg_data_enable <= 1'b0;
            r_cfg_data        <= 8'd0;
            r_filt_hold       <= 1'b0;
            r_done            <= 1'b0;
            r_err             <= 1'b0;
            r_word_cnt        <= 5'd0;
            r_drain_cnt       <= 8'd0;
            r_idle_cnt        <= 8'd0;
        end else begin
            r_cfg_enable      <= w_cfg_enable_n;
            r_cfg_data_enable <= w_xfer;
            r_filt_hold       <= w_filt_hold_n;
            r_done            <= w_done_n;
            r_err             <= w_err_n;

            if (w_xfer) begin
                r_cfg_data <= i_s_data;
            end

            // Holds after abort/timeout so the host can see progress.
            if (w_start) begin
                r_word_cnt <= 5'd0;
            end else if (w_xfer) begin
                r_word_cnt <= r_word_cnt + 5'd1;
            end

            if (w_start) begin
                r_drain_cnt <= DRAIN_INIT;
            end else if ((r_state == S_DRAIN) && (r_drain_cnt != 8'd0)) begin
                r_drain_cnt <= r_drain_cnt - 8'd1;
            end

            // Held at zero outside LOAD, so LOAD entry starts from zero.
            if ((r_state != S_LOAD) || w_xfer) begin
                r_idle_cnt <= 8'd0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 8'd1;
            end
        end
    end

    assign o_cfg_enable      = r_cfg_enable;
    assign o_cfg_data_enable = r_cfg_data_enable;
    assign o_cfg_data        = r_cfg_data;
    assign o_filt_hold       = r_filt_hold;
    assign o_done            = r_done;
    assign o_err             = r_err;
    assign o_word_cnt        = r_word_cnt;

endmodule

// File: tb/tb_coef_load_ctrl.sv
// tb_coef_load_ctrl: directed bench for coef_load_ctrl with a
// cycle-stamped scoreboard of expected cfg_data shift pulses.
module tb_coef_load_ctrl;

    localparam int DRAIN = 4;
    localparam int TMO   = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic       i_s_valid = 1'b0;
    logic [7:0] i_s_data = 8'd0;
    logic       o_s_ready;
    logic       o_cfg_enable;
    logic       o_cfg_data_enable;
    logic [7:0] o_cfg_data;
    logic       o_filt_hold;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [4:0] o_word_cnt;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0;
    int   failures = 0;
    int   pulses = 0;
    int   cyc = 0;
    int   p0;

    coef_load_ctrl #(
        .DRAIN_CYCLES(DRAIN),
        .TIMEOUT     (TMO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_s_valid        (i_s_valid),
        .i_s_data         (i_s_data),
        .o_s_ready        (o_s_ready),
        .o_cfg_enable     (o_cfg_enable),
        .o_cfg_data_enable(o_cfg_data_enable),
        .o_cfg_data       (o_cfg_data),
        .o_filt_hold      (o_filt_hold),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err            (o_err),
        .o_word_cnt       (o_word_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every shift pulse must match the oldest expected byte and its cycle.
    always @(negedge clk) begin
        if (rst_n && o_cfg_data_enable) begin
            pulses = pulses + 1;
            chk("sb_pending", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                chk("cfg_data", o_cfg_data, e_mon.data);
                chk("pulse_cycle", cyc, e_mon.cyc);
            end
            chk("pulse_cfg_en", o_cfg_enable, 1);
        end
        if (o_done || o_err) begin
            chk("done_err_excl", o_done & o_err, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a load and walk through DRAIN; returns in the first LOAD cycle.
    task automatic do_start(input logic hold);
        i_start = 1'b1;
        @(negedge clk);
        chk("hold_before_start", o_filt_hold, 0);
        tick();
        if (!hold) i_start = 1'b0;
        for (int i = 0; i < DRAIN; i++) begin
            @(negedge clk);
            chk("drain_ready", o_s_ready, 0);
            chk("drain_cfg_en", o_cfg_enable, 0);
            if (i == 0) begin
                chk("drain_hold", o_filt_hold, 1);
                chk("drain_busy", o_busy, 1);
                chk("drain_wcnt", o_word_cnt, 0);
            end
            tick();
        end
        chk("load_cfg_en", o_cfg_enable, 1);
    endtask

    task automatic drive_byte(input logic [7:0] d);
        i_s_valid = 1'b1;
        i_s_data  = d;
        sb.push_back('{d, cyc + 1});
        @(negedge clk);
        chk("s_ready", o_s_ready, 1);
        tick();
        i_s_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("gap_busy", o_busy, 1);
        tick();
    endtask

    // Called in the FINISH cycle of a complete load.
    task automatic finish_check(input logic restart);
        @(negedge clk);
        chk("fin_cfg_en", o_cfg_enable, 1);
        chk("fin_ready", o_s_ready, 0);
        chk("fin_done", o_done, 0);
        chk("fin_busy", o_busy, 1);
        tick();
        @(negedge clk);
        chk("done_pulse", o_done, 1);
        chk("done_err", o_err, 0);
        chk("done_busy", o_busy, 0);
        chk("done_cfg_en", o_cfg_enable, 0);
        chk("done_hold", o_filt_hold, 0);
        chk("done_wcnt", o_word_cnt, 17);
        tick();
        @(negedge clk);
        chk("done_clear", o_done, 0);
        if (restart) begin
            chk("restart_hold", o_filt_hold, 1);
            chk("restart_busy", o_busy, 1);
            chk("restart_wcnt", o_word_cnt, 0);
        end else begin
            chk("post_busy", o_busy, 0);
        end
        tick();
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_ready", o_s_ready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_cfg_en", o_cfg_enable, 0);
        chk("rst_cde", o_cfg_data_enable, 0);
        chk("rst_cdata", o_cfg_data, 0);
        chk("rst_hold", o_filt_hold, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_wcnt", o_word_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Back-to-back load
        p0 = pulses;
        do_start(1'b0);
        for (int i = 0; i < 17; i++) drive_byte(8'(8'h0F + i));
        finish_check(1'b0);
        chk("b2b_pulses", pulses - p0, 17);
        chk("b2b_sb_empty", sb.size(), 0);

        // Valid toggled every other cycle
        p0 = pulses;
        do_start(1'b0);
        for (int i = 0; i < 17; i++) begin
            drive_byte(8'(8'h0F + i));
            if (i < 16) idle_cycle();
        end
        finish_check(1'b0);
        chk("tog_pulses", pulses - p0, 17);
        chk("tog_sb_empty", sb.size(), 0);

        // Timeout after 5 bytes
        p0 = pulses;
        do_start(1'b0);
        for (int i = 0; i < 5; i++) drive_byte(8'(8'hA0 + i));
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            chk("tmo_wait_err", o_err, 0);
            chk("tmo_wait_busy", o_busy, 1);
            tick();
        end
        @(negedge clk);
        chk("tmo_err", o_err, 1);
        chk("tmo_done", o_done, 0);
        chk("tmo_wcnt", o_word_cnt, 5);
        chk("tmo_cfg_en", o_cfg_enable, 0);
        chk("tmo_hold", o_filt_hold, 0);
        chk("tmo_busy", o_busy, 0);
        tick();
        @(negedge clk);
        chk("tmo_err_clear", o_err, 0);
        chk("tmo_no_done", o_done, 0);
        tick();
        chk("tmo_pulses", pulses - p0, 5);
        chk("tmo_sb_empty", sb.size(), 0);

        // Abort together with byte 3
        p0 = pulses;
        do_start(1'b0);
        for (int i = 0; i < 3; i++) drive_byte(8'(8'hC0 + i));
        i_abort   = 1'b1;
        i_s_valid = 1'b1;
        i_s_data  = 8'hC3;
        @(negedge clk);
        chk("abort_ready", o_s_ready, 0);
        chk("abort_cfg_en", o_cfg_enable, 1);
        chk("abort_err_early", o_err, 0);
        tick();
        i_abort   = 1'b0;
        i_s_valid = 1'b0;
        @(negedge clk);
        chk("abort_err", o_err, 1);
        chk("abort_wcnt", o_word_cnt, 3);
        chk("abort_busy", o_busy, 0);
        chk("abort_cfg_en_low", o_cfg_enable, 0);
        chk("abort_hold_low", o_filt_hold, 0);
        chk("abort_cde_low", o_cfg_data_enable, 0);
        tick();
        @(negedge clk);
        chk("abort_err_clear", o_err, 0);
        chk("abort_wcnt_hold", o_word_cnt, 3);
        tick();
        chk("abort_pulses", pulses - p0, 3);
        chk("abort_sb_empty", sb.size(), 0);

        // Start held high through a whole load
        p0 = pulses;
        do_start(1'b1);
        for (int i = 0; i < 17; i++) drive_byte(8'(8'h50 + i));
        finish_check(1'b1);
        chk("hold_pulses", pulses - p0, 17);
        i_start = 1'b0;
        i_abort = 1'b1;
        @(negedge clk);
        chk("drain_abort_busy", o_busy, 1);
        tick();
        i_abort = 1'b0;
        @(negedge clk);
        chk("drain_abort_err", o_err, 1);
        chk("drain_abort_busy_low", o_busy, 0);
        chk("drain_abort_hold_low", o_filt_hold, 0);
        tick();

        // Reset during LOAD
        p0 = pulses;
        do_start(1'b0);
        drive_byte(8'h11);
        drive_byte(8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_ready", o_s_ready, 0);
        chk("mrst_busy", o_busy, 0);
        chk("mrst_cfg_en", o_cfg_enable, 0);
        chk("mrst_cde", o_cfg_data_enable, 0);
        chk("mrst_cdata", o_cfg_data, 0);
        chk("mrst_hold", o_filt_hold, 0);
        chk("mrst_done", o_done, 0);
        chk("mrst_err", o_err, 0);
        chk("mrst_wcnt", o_word_cnt, 0);
        chk("mrst_sb_left", sb.size(), 1);
        sb.delete();
        chk("mrst_pulses", pulses - p0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_err", o_err, 0);
            chk("post_rst_done", o_done, 0);
            chk("post_rst_busy", o_busy, 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coef_load_ctrl.md
COEF_LOAD_CTRL -- requirements
Module: coef_load_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 16, idle cycles with filt_hold asserted before loading starts (range 0..255).
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum consecutive LOAD cycles without a transfer before abort (range 1..255).
REQ-003 clk  input  1  clock; all registers update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a reconfiguration; sampled in IDLE only.
REQ-006 abort  input  1  host cancels an in-progress reconfiguration.
REQ-007 s_valid  input  1  host byte valid.
REQ-008 s_data  input  8  host byte.
REQ-009 s_ready  output  1  combinational; high in LOAD when abort=0.
REQ-010 cfg_enable  output  1  registered; drives the coefficient register's config_enable.
REQ-011 cfg_data_enable  output  1  registered one-cycle shift pulse to the coefficient register.
REQ-012 cfg_data  output  8  registered; byte shifted on cfg_data_enable.
REQ-013 filt_hold  output  1  registered; stalls the FIR datapath while high.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 err  output  1  one-cycle pulse on abort or timeout.
REQ-017 word_cnt  output  5  number of bytes accepted in the current load (0..17).

Function
REQ-018 SHALL implement the states IDLE, DRAIN, LOAD and FINISH.
REQ-019 A transfer SHALL occur in any cycle where s_valid and s_ready are both high.
REQ-020 IDLE: start=1 SHALL go to DRAIN next cycle with filt_hold=1, load the drain counter with DRAIN_CYCLES and clear word_cnt; start in any other state SHALL be ignored.
REQ-021 DRAIN: the block SHALL stay DRAIN_CYCLES cycles, then enter LOAD; if DRAIN_CYCLES=0, LOAD SHALL follow DRAIN after 1 cycle.
REQ-022 cfg_enable SHALL be 1 in every LOAD and FINISH cycle and 0 otherwise.
REQ-023 Each transfer SHALL set cfg_data=s_data and cfg_data_enable=1 for exactly the following cycle, then increment word_cnt.
REQ-024 Byte order SHALL be: byte 0 = tap_num (bits[3:0] used), bytes 1..16 = h_15 down to h_0; after 17 shifts, h_0 holds byte 16 and tap_num holds byte 0[3:0].
REQ-025 The 17th transfer SHALL move the state LOAD->FINISH; s_ready SHALL be 0 in FINISH.
REQ-026 FINISH SHALL last exactly 1 cycle, during which the final cfg_data_enable pulse is high; next cycle: IDLE, cfg_enable=0, filt_hold=0, done=1 for 1 cycle.
REQ-027 Idle counter (8-bit): SHALL clear on LOAD entry and on every transfer, and increment each LOAD cycle with no transfer; reaching TIMEOUT SHALL move the state to IDLE with err=1 for 1 cycle.
REQ-028 abort=1 in DRAIN or LOAD SHALL move the state to IDLE next cycle with err=1; abort takes priority over a simultaneous transfer (s_ready=0) and over timeout; abort in IDLE or FINISH SHALL be ignored.
REQ-029 A cfg_data_enable pulse from a transfer in the cycle before an abort or timeout SHALL still occur while cfg_enable=1; no pulse SHALL ever occur with cfg_enable=0.
REQ-030 On abort or timeout, already-shifted words SHALL remain in place; filt_hold and cfg_enable SHALL drop together on IDLE entry; word_cnt SHALL hold its value until the next start.
REQ-031 done and err SHALL never be asserted in the same cycle.

Reset
REQ-032 rst_n=0 SHALL force IDLE immediately; cfg_enable, cfg_data_enable, cfg_data, filt_hold, done, err, word_cnt, and all counters SHALL be 0; s_ready and busy SHALL be 0.
REQ-033 Reset asserted mid-LOAD SHALL cancel the load without generating an err or done pulse.

Verification
REQ-034 DRAIN_CYCLES=4, start, then 17 back-to-back bytes 0x0F,0x10..0x1F -> filt_hold rises 1 cycle after start, s_ready rises after 4 DRAIN cycles, 17 consecutive data_enable pulses, done 1 cycle after FINISH, word_cnt=17.
REQ-035 Same load with s_valid toggled every other cycle -> exactly 17 pulses, each 1 cycle after its transfer, with cfg_data matching each byte.
REQ-036 TIMEOUT=8, stop after 5 bytes -> err pulse 8 cycles after the 5th transfer, word_cnt=5, cfg_enable and filt_hold low, no done pulse.
REQ-037 abort asserted together with s_valid on byte 3 -> byte 3 not accepted, byte 2's pulse still occurs, err=1 next cycle, word_cnt=3.
REQ-038 start held high through an entire load -> a single load occurs; a new DRAIN begins only from IDLE after done.
REQ-039 rst_n pulsed low during LOAD -> all outputs 0 asynchronously, no err or done pulse, state IDLE.
